// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller.
//
// Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
// using a single one-bit full adder and a carry flip-flop between bits.
// A start accepted in IDLE or DONE captures the operands; WIDTH cycles later
// done pulses for one cycle and S/Cout/V hold the result until the next
// accepted start or reset.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  request strobe, sampled only in IDLE or DONE
//   A, B   operands, captured on an accepted start
//   Cin    carry-in, captured on an accepted start
//   busy   high while the addition is in progress
//   done   one-cycle pulse when S/Cout/V become valid
//   S      sum
//   Cout   carry out of bit WIDTH-1
//   V      signed overflow (carry into MSB xor carry out of MSB)
//
// The file also carries the one-bit fullAdder cell the controller sequences,
// so the design compiles on its own.

module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             fa_s, fa_cout;
    logic             load;
    logic             last_bit;

    fullAdder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    assign load     = start && (state_q == StIdle || state_q == StDone);
    assign last_bit = (cnt_q == LastCnt);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        cnt_d    = cnt_q;
        if (load) begin
            a_sh_d   = A;
            b_sh_d   = B;
            carry_d  = Cin;
            cnt_d    = '0;
            sum_sh_d = '0;
            cmsb_d   = 1'b0;
        end else if (state_q == StRun) begin
            // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_cout;
            if (last_bit) begin
                cmsb_d = carry_q;
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode registered state only. During RUN the carry flop holds
    // intermediate carries, so results are masked to zero until DONE; outside
    // RUN the shift/carry registers are frozen and hold the last result.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        S    = '0;
        Cout = 1'b0;
        V    = 1'b0;
        if (state_q != StRun) begin
            S    = sum_sh_q;
            Cout = carry_q;
            V    = cmsb_q ^ carry_q;
        end
    end

endmodule
